seven_seg_scan_driver: RTL and testbench
========================================

# seven_seg_scan_driver

Parametrised, time-multiplexed driver for an N-digit common-anode/cathode seven-segment display. It accepts a packed hex value plus per-digit decimal-point and blank masks, latches them through a tear-free frame-synchronous update handshake, and scans one digit at a time at a programmable refresh rate. It sits between the board-level display pins and any user logic that needs to show numeric state, and replaces single-digit combinational decoders.

## Interface

Parameters:
- DIGITS, 4, number of digits scanned (1..8)
- REFRESH_DIV, 100000, clock cycles each digit is enabled per frame (min 2)
- ACTIVE_LOW, 1, 1 = seg/dp/an outputs driven active-low; 0 = active-high

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- value  in  4*DIGITS  hex nibbles; nibble i (bits 4i+3:4i) shown on digit i, digit 0 rightmost
- dp_in  in  DIGITS  decimal point request per digit
- blank_in  in  DIGITS  force digit fully dark (segments and dp) when 1
- load  in  1  single-cycle strobe: capture value/dp_in/blank_in
- pending  out  1  captured data not yet displayed
- frame_tick  out  1  one-cycle pulse when scan wraps and new frame begins
- seg  out  7  segments, bit0=a ... bit6=g
- dp  out  1  decimal point
- an  out  DIGITS  digit enables, one-hot (in asserted polarity)

## Operation

- Prescaler counts 0..REFRESH_DIV-1; on terminal count it returns to 0 and digit index advances; index DIGITS-1 wraps to 0 (frame wrap).
- Shadow registers capture value/dp_in/blank_in on any cycle with load=1; a later load before the wrap overwrites (latest wins).
- Active registers (what is displayed) load from shadow only at frame wrap, and only if pending; a load in the wrap cycle itself is applied at that same edge (bypasses shadow).
- pending: set the edge after load; cleared at the wrap edge that applies the data; load in wrap cycle leaves pending 0.
- Decode (active-high form, a=bit0): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. ACTIVE_LOW inverts seg, dp, an.
- Blanked digit: an still asserted for its slot, seg and dp all off.
- Only one an bit asserted at any time; never two.

## Timing

- Reset (async assert): prescaler 0, index 0, shadow/active cleared (value 0, dp 0, blank 0), pending 0, frame_tick 0, seg/dp/an all deasserted (all-ones if ACTIVE_LOW).
- seg/dp/an are registered: one cycle after reset release they show digit 0 of active data ("0").
- Each digit enabled for exactly REFRESH_DIV cycles; frame period DIGITS*REFRESH_DIV cycles.
- Output registers follow index with 1-cycle latency; new active data visible on outputs 1 cycle after the wrap edge, on digit 0.
- frame_tick high for the single cycle after the wrap edge, coincident with first output cycle of digit 0.
- Load-to-display latency: 1..DIGITS*REFRESH_DIV+1 cycles.
- Reset mid-frame: outputs dark immediately (asynchronous), pending data discarded.

## Configuration

- SEG_LZ_SUPPRESS_EN defined: leading-zero suppression; a digit whose nibble is 0 and all higher nibbles are 0 is blanked (seg off; dp still honoured). Digit 0 is never suppressed. Evaluated on active data.
- Undefined: all nibbles, including leading zeros, displayed; suppression logic absent.

## Test plan

- Reset/scan: DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1, release rst -> an cycles 1110,1101,1011,0111 each 4 cycles, seg=7'h40 (inverted 0x3F); frame_tick every 16 cycles.
- Update handshake: load value=16'h12AF mid-frame -> pending=1 until wrap; next frame digits 0..3 show F(8E),A(88),2(A4),1(F9); pending=0.
- Latest wins / wrap-cycle load: load 16'h1111 then 16'h2222 in same frame -> only 2222 displayed; load 16'h3333 on wrap cycle -> displayed next cycle, pending never rises.
- Blank/dp: blank_in=4'b0100, dp_in=4'b0001 -> digit 2 fully dark, dp asserted only during digit 0 slot.
- Leading zeros (SEG_LZ_SUPPRESS_EN): value 16'h0042 -> digits 3,2 dark, 4 and 2 shown; value 16'h0000 -> digit 0 shows 0; without macro, 0042 shows 0,0,4,2.
- Reset mid-frame: assert rst during digit 2 with pending=1 -> an/seg/dp all 1 same cycle; after release display shows 0000, pending 0.

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with frame-synchronous, tear-free data update.
// Optional macro SEG_LZ_SUPPRESS_EN enables leading-zero suppression on the displayed data.
module seven_seg_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  load,
  output logic                  pending,
  output logic                  frame_tick,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0]     PRESC_TC = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  localparam logic [6:0]        SEG_POL  = {7{ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] AN_POL   = {DIGITS{ACTIVE_LOW}};

  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] sh_val_q, act_val_q, act_val_d;
  logic [DIGITS-1:0]   sh_dp_q, act_dp_q, act_dp_d;
  logic [DIGITS-1:0]   sh_blank_q, act_blank_q, act_blank_d;
  logic                pending_q, wrap_q, tick_q;
  logic [6:0]          seg_q;
  logic                dp_q;
  logic [DIGITS-1:0]   an_q;

  logic                tc, wrap;
  logic [3:0]          nib;
  logic                dp_sel, blk_sel, seg_off, dp_hi;
  logic [6:0]          seg_hi;
  logic [DIGITS-1:0]   an_hi;
`ifdef SEG_LZ_SUPPRESS_EN
  logic [DIGITS-1:0]   lz;
  logic                above_zero;
`endif

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  // Scan timing and active-data update; a load in the wrap cycle bypasses the shadow.
  always_comb begin
    tc      = (presc_q == PRESC_TC);
    wrap    = tc && (idx_q == IDX_LAST);
    presc_d = tc ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (tc) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    act_val_d   = act_val_q;
    act_dp_d    = act_dp_q;
    act_blank_d = act_blank_q;
    if (wrap) begin
      if (load) begin
        act_val_d   = value;
        act_dp_d    = dp_in;
        act_blank_d = blank_in;
      end else if (pending_q) begin
        act_val_d   = sh_val_q;
        act_dp_d    = sh_dp_q;
        act_blank_d = sh_blank_q;
      end
    end
  end

  always_comb begin
    nib     = '0;
    dp_sel  = 1'b0;
    blk_sel = 1'b0;
    an_hi   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib      = act_val_q[4*i +: 4];
        dp_sel   = act_dp_q[i];
        blk_sel  = act_blank_q[i];
        an_hi[i] = 1'b1;
      end
    end
`ifdef SEG_LZ_SUPPRESS_EN
    lz         = '0;
    above_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      above_zero = above_zero && (act_val_q[4*i +: 4] == 4'h0);
      lz[i]      = above_zero;
    end
    seg_off = blk_sel || ((lz & an_hi) != '0);
`else
    seg_off = blk_sel;
`endif
    seg_hi = seg_off ? 7'h00 : hex2seg(nib);
    dp_hi  = dp_sel & ~blk_sel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q     <= '0;
      idx_q       <= '0;
      sh_val_q    <= '0;
      sh_dp_q     <= '0;
      sh_blank_q  <= '0;
      act_val_q   <= '0;
      act_dp_q    <= '0;
      act_blank_q <= '0;
      pending_q   <= 1'b0;
      wrap_q      <= 1'b0;
      tick_q      <= 1'b0;
      seg_q       <= SEG_POL;
      dp_q        <= ACTIVE_LOW;
      an_q        <= AN_POL;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      if (load) begin
        sh_val_q   <= value;
        sh_dp_q    <= dp_in;
        sh_blank_q <= blank_in;
      end
      act_val_q   <= act_val_d;
      act_dp_q    <= act_dp_d;
      act_blank_q <= act_blank_d;
      pending_q   <= wrap ? 1'b0 : (load | pending_q);
      // Outputs lag the index by one cycle, so the tick is delayed to line up with digit 0.
      wrap_q      <= wrap;
      tick_q      <= wrap_q;
      seg_q       <= seg_hi ^ SEG_POL;
      dp_q        <= dp_hi ^ ACTIVE_LOW;
      an_q        <= an_hi ^ AN_POL;
    end
  end

  assign pending    = pending_q;
  assign frame_tick = tick_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver (DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1): vector table plus scoreboard.
module tb_seven_seg_scan_driver;
  localparam int DIGITS = 4;
  localparam int RDIV   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic        load = 1'b0;
  logic        pending, frame_tick, dp;
  logic [6:0]  seg;
  logic [3:0]  an;

  seven_seg_scan_driver #(.DIGITS(DIGITS), .REFRESH_DIV(RDIV), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .blank_in(blank_in), .load(load),
    .pending(pending), .frame_tick(frame_tick), .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] val;
    logic [3:0]  dpm;
    logic [3:0]  blk;
    logic [27:0] segs;   // expected active-low seg per digit, digit 0 in [6:0]
    logic [3:0]  dpo;    // expected active-low dp per digit
  } vec_t;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [27:0] segs, input logic [3:0] dpo);
    exp_t e;
    for (int d = 0; d < DIGITS; d++) begin
      e.an  = ~(4'b0001 << d);
      e.seg = segs[7*d +: 7];
      e.dp  = dpo[d];
      sb.push_back(e);
    end
  endtask

  task automatic wait_tick(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) got = 1'b1;
    end
    chk({name, "_tick_seen"}, {31'b0, got}, 32'd1);
  endtask

  // Called on the negedge where frame_tick is high; samples each digit one cycle into its slot.
  task automatic check_frame(input string name);
    exp_t e;
    @(negedge clk);
    for (int d = 0; d < DIGITS; d++) begin
      if (d > 0) repeat (RDIV) @(negedge clk);
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s_sb: no expected entry for digit %0d", name, d);
      end else begin
        e = sb.pop_front();
        chk($sformatf("%s_d%0d_an", name, d), {28'b0, an}, {28'b0, e.an});
        chk($sformatf("%s_d%0d_seg", name, d), {25'b0, seg}, {25'b0, e.seg});
        chk($sformatf("%s_d%0d_dp", name, d), {31'b0, dp}, {31'b0, e.dp});
      end
    end
  endtask

  task automatic drive_load(input logic [15:0] v, input logic [3:0] dm, input logic [3:0] bm);
    value    = v;
    dp_in    = dm;
    blank_in = bm;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_on && !rst) chk("an_onehot", $countones(~an), 32'd1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    vecs[0] = '{16'h12AF, 4'b0000, 4'b0000, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1111};
    vecs[1] = '{16'h3456, 4'b0001, 4'b0100, {7'h30, 7'h7F, 7'h12, 7'h02}, 4'b1110};
    vecs[2] = '{16'hC7E9, 4'b1010, 4'b0000, {7'h46, 7'h78, 7'h06, 7'h10}, 4'b0101};
    vecs[4] = '{16'hDB80, 4'b1111, 4'b1001, {7'h7F, 7'h03, 7'h00, 7'h7F}, 4'b1001};
`ifdef SEG_LZ_SUPPRESS_EN
    vecs[3] = '{16'h0042, 4'b0000, 4'b0000, {7'h7F, 7'h7F, 7'h19, 7'h24}, 4'b1111};
    vecs[5] = '{16'h0000, 4'b0010, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1101};
`else
    vecs[3] = '{16'h0042, 4'b0000, 4'b0000, {7'h40, 7'h40, 7'h19, 7'h24}, 4'b1111};
    vecs[5] = '{16'h0000, 4'b0010, 4'b0000, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1101};
`endif

    repeat (3) @(negedge clk);
    chk("rst_an", {28'b0, an}, 32'hF);
    chk("rst_seg", {25'b0, seg}, 32'h7F);
    chk("rst_dp", {31'b0, dp}, 32'd1);
    chk("rst_pending", {31'b0, pending}, 32'd0);
    chk("rst_tick", {31'b0, frame_tick}, 32'd0);

    rst = 1'b0;
    @(negedge clk);
    chk("first_an", {28'b0, an}, 32'hE);
    chk("first_seg", {25'b0, seg}, 32'h40);
    chk("first_dp", {31'b0, dp}, 32'd1);
    chk_on = 1'b1;
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (an === 4'hE) cnt++;
      else break;
    end
    chk("digit0_slot_len", cnt, RDIV);
    chk("second_an", {28'b0, an}, 32'hD);

    wait_tick("sync");
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cnt++;
      if (frame_tick === 1'b1) break;
    end
    chk("frame_period", cnt, DIGITS * RDIV);

    for (int k = 0; k < 6; k++) begin
      wait_tick($sformatf("v%0d_sync", k));
      repeat (5) @(negedge clk);
      push_frame(vecs[k].segs, vecs[k].dpo);
      drive_load(vecs[k].val, vecs[k].dpm, vecs[k].blk);
      chk($sformatf("v%0d_pending_set", k), {31'b0, pending}, 32'd1);
      wait_tick($sformatf("v%0d_apply", k));
      chk($sformatf("v%0d_pending_clr", k), {31'b0, pending}, 32'd0);
      check_frame($sformatf("v%0d", k));
    end

    // Two loads within one frame: only the later one may appear.
    wait_tick("lw_sync");
    repeat (2) @(negedge clk);
    drive_load(16'h1111, 4'b0000, 4'b0000);
    repeat (3) @(negedge clk);
    push_frame({7'h24, 7'h24, 7'h24, 7'h24}, 4'b1111);
    drive_load(16'h2222, 4'b0000, 4'b0000);
    chk("lw_pending", {31'b0, pending}, 32'd1);
    wait_tick("lw_apply");
    check_frame("lw");

    // Load in the wrap cycle itself (offset 14 from the tick cycle): pending must stay low.
    wait_tick("wc_sync");
    repeat (14) @(negedge clk);
    chk("wc_pending_before", {31'b0, pending}, 32'd0);
    push_frame({7'h30, 7'h30, 7'h30, 7'h30}, 4'b1111);
    drive_load(16'h3333, 4'b0000, 4'b0000);
    chk("wc_pending_after", {31'b0, pending}, 32'd0);
    @(negedge clk);
    chk("wc_tick", {31'b0, frame_tick}, 32'd1);
    chk("wc_pending_tick", {31'b0, pending}, 32'd0);
    chk("wc_seg_now", {25'b0, seg}, 32'h30);
    check_frame("wc");

    // Reset during digit 2 with data pending: outputs go dark at once, pending data dropped.
    wait_tick("rm_sync");
    repeat (2) @(negedge clk);
    drive_load(16'h5555, 4'b1111, 4'b0000);
    repeat (6) @(negedge clk);
    chk("rm_pending", {31'b0, pending}, 32'd1);
    chk("rm_an_digit2", {28'b0, an}, 32'hB);
    chk_on = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rm_an", {28'b0, an}, 32'hF);
    chk("rm_seg", {25'b0, seg}, 32'h7F);
    chk("rm_dp", {31'b0, dp}, 32'd1);
    chk("rm_pending_clr", {31'b0, pending}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rm_rel_an", {28'b0, an}, 32'hE);
    chk("rm_rel_seg", {25'b0, seg}, 32'h40);
    chk_on = 1'b1;
    push_frame({7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111);
    wait_tick("rm_frame");
    chk("rm_frame_pending", {31'b0, pending}, 32'd0);
    check_frame("rm");

    chk("sb_drained", sb.size(), 32'd0);
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
